// File: rtl/layer_scheduler_pkg.sv
// Shared types and the round-robin grant helper
// for the clocked neuron-layer scheduler.
package layer_sched_pkg;

  localparam int max_n = 32;

  typedef enum logic [1:0] {
    IDLE,
    BCAST,
    DRAIN,
    DONE
  } sched_state_t;

  // First set bit of req scanning ptr, ptr+1, ... wrapping at n.
  function automatic logic [max_n-1:0] rr_onehot(
    input logic [max_n-1:0] req,
    input logic [4:0]       ptr,
    input int               n
  );
    logic [max_n-1:0] g;
    logic             found;
    int               k;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < max_n; i++) begin
      if (!found && i < n) begin
        k = int'(ptr) + i;
        if (k >= n) k = k - n;
        if (req[k[4:0]]) begin
          g[k[4:0]] = 1'b1;
          found     = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/layer_scheduler_if.sv
// Handshake bundle between presynaptic neurons,
// the layer ROM and the layer neuron array.
interface layer_scheduler_if #(
  parameter int neurons_in  = 4,
  parameter int neurons_out = 4,
  parameter int cnt_w       = 16
);

  logic [neurons_in-1:0]  req_in;
  logic [neurons_in-1:0]  ack_in;
  logic [neurons_in-1:0]  sel;
  logic [neurons_out-1:0] req_out;
  logic [neurons_out-1:0] ack_out;
  logic                   busy;
  logic [cnt_w-1:0]       spike_cnt;

  modport master (
    output req_in,
    output ack_out,
    input  ack_in,
    input  sel,
    input  req_out,
    input  busy,
    input  spike_cnt
  );

  modport slave (
    input  req_in,
    input  ack_out,
    output ack_in,
    output sel,
    output req_out,
    output busy,
    output spike_cnt
  );

endinterface

// File: rtl/layer_scheduler_rr_pick.sv
// Combinational round-robin picker: one-hot grant,
// its index, and whether anything is requesting.
module rr_pick
  import layer_sched_pkg::*;
#(
  parameter  int n  = 4,
  localparam int pw = (n > 1) ? $clog2(n) : 1
) (
  input  logic [n-1:0]  req,
  input  logic [pw-1:0] ptr,
  output logic [n-1:0]  gnt,
  output logic [pw-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    gnt     = n'(rr_onehot(max_n'(req), 5'(ptr), n));
    gnt_idx = '0;
    for (int i = 0; i < n; i++) begin
      if (gnt[i]) gnt_idx = pw'(i);
    end
    any = |req;
  end

endmodule

// File: rtl/layer_scheduler.sv
// Clocked arbiter/fork for a neuron layer: grants one
// presynaptic request, broadcasts it, joins the acks.
module layer_scheduler
  import layer_sched_pkg::*;
#(
  parameter int neurons_in  = 4,
  parameter int neurons_out = 4,
  parameter int sync_stages = 2,
  parameter int cnt_w       = 16
) (
  input logic         clk,
  input logic         rst,
  layer_scheduler_if.slave bus
);

  localparam int pw = (neurons_in > 1) ? $clog2(neurons_in) : 1;
  localparam int rw = sync_stages * neurons_in;
  localparam int aw = sync_stages * neurons_out;

  logic [rw-1:0]          rq_sh;
  logic [aw-1:0]          ak_sh;
  logic [neurons_in-1:0]  rq;
  logic [neurons_out-1:0] ak;

  sched_state_t           state;
  logic [pw-1:0]          ptr;
  logic [pw-1:0]          g;

  logic [neurons_in-1:0]  pick_gnt;
  logic [pw-1:0]          pick_idx;
  logic                   pick_any;

  // Shift-register synchronisers; the oldest slice is the synced value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rq_sh <= '0;
      ak_sh <= '0;
    end else begin
      rq_sh <= (rq_sh << neurons_in) | rw'(bus.req_in);
      ak_sh <= (ak_sh << neurons_out) | aw'(bus.ack_out);
    end
  end

  assign rq = rq_sh[rw-1 -: neurons_in];
  assign ak = ak_sh[aw-1 -: neurons_out];

  rr_pick #(.n(neurons_in)) u_pick (
    .req     (rq),
    .ptr     (ptr),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      g             <= '0;
      bus.ack_in    <= '0;
      bus.sel       <= '0;
      bus.req_out   <= '0;
      bus.busy      <= 1'b0;
      bus.spike_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            g           <= pick_idx;
            bus.sel     <= pick_gnt;
            bus.req_out <= '1;
            bus.busy    <= 1'b1;
            state       <= BCAST;
          end
        end
        BCAST: begin
          if (&ak) begin
            bus.req_out <= '0;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (ak == '0) begin
            bus.ack_in <= bus.sel;
            state      <= DONE;
          end
        end
        DONE: begin
          // Also exits at once if the requester dropped early.
          if (!rq[g]) begin
            bus.ack_in <= '0;
            bus.sel    <= '0;
            bus.busy   <= 1'b0;
            state      <= IDLE;
            ptr        <= (g == pw'(neurons_in - 1)) ? '0 : g + 1'b1;
            if (bus.spike_cnt != '1)
              bus.spike_cnt <= bus.spike_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_scheduler.sv
// Self-checking bench for layer_scheduler: directed timing
// sequences, a grant-order table and randomized batches.
module tb_layer_scheduler;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  layer_scheduler_if #(.neurons_in(4), .neurons_out(4), .cnt_w(16)) b0 ();
  layer_scheduler_if #(.neurons_in(4), .neurons_out(4), .cnt_w(2))  b1 ();

  layer_scheduler #(
    .neurons_in(4), .neurons_out(4), .sync_stages(2), .cnt_w(16)
  ) d0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  layer_scheduler #(
    .neurons_in(4), .neurons_out(4), .sync_stages(2), .cnt_w(2)
  ) d1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  typedef struct packed {
    logic [3:0] req;
    logic [2:0] n;
    logic [7:0] ord;
  } vec_t;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         mode   = 0;
  logic [3:0] prev_req;
  int         got [4];
  int         got_n;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // One clock; sample after the edge, then let the neuron model react.
  task automatic tick();
    @(posedge clk);
    #1;
    n_chk++;
    if (!$onehot0(b0.ack_in) || !$onehot0(b0.sel) ||
        !(b0.req_out inside {4'h0, 4'hF}) ||
        (b0.busy != (b0.sel != 4'h0))) begin
      n_fail++;
      $display("FAIL invariant: ack_in=%b sel=%b req_out=%b busy=%b required onehot0, onehot0, all-equal, busy==(sel!=0)",
               b0.ack_in, b0.sel, b0.req_out, b0.busy);
    end
    case (mode)
      1: b0.ack_out = prev_req;
      2: begin
        for (int j = 0; j < 4; j++)
          if (b0.ack_out[j] !== b0.req_out[j] && $urandom_range(1, 0) == 1)
            b0.ack_out[j] = b0.req_out[j];
      end
      default: ;
    endcase
    prev_req   = b0.req_out;
    b1.ack_out = b1.req_out;
  endtask

  task automatic wait_for(input int sig, input logic [3:0] val,
                          input string name);
    logic [3:0] v;
    bit         ok;
    ok = 1'b0;
    v  = 4'h0;
    for (int t = 0; t < 200 && !ok; t++) begin
      tick();
      case (sig)
        0:       v = b0.req_out;
        1:       v = b0.ack_in;
        2:       v = {3'b0, b0.busy};
        3:       v = b1.ack_in;
        default: v = {3'b0, b1.busy};
      endcase
      ok = (v == val);
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: timeout, last %b required %b", name, v, val);
    end
  endtask

  task automatic wait_ack(output int idx, input string name);
    idx = -1;
    for (int t = 0; t < 300 && idx < 0; t++) begin
      tick();
      for (int j = 0; j < 4; j++)
        if (b0.ack_in[j]) idx = j;
    end
    n_chk++;
    if (idx < 0) begin
      n_fail++;
      $display("FAIL %s: timeout, ack_in %b required nonzero", name, b0.ack_in);
    end
  endtask

  task automatic do_reset(input int n);
    rst        = 1'b1;
    b0.req_in  = 4'h0;
    b0.ack_out = 4'h0;
    b1.req_in  = 4'h0;
    prev_req   = 4'h0;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
  endtask

  // Raise every bit of req at once; each drops after its own ack.
  task automatic run_batch(input logic [3:0] req);
    int idx;
    got_n = 0;
    for (int i = 0; i < 4; i++) got[i] = -1;
    b0.req_in = req;
    while (b0.req_in != 4'h0 && got_n < 4) begin
      wait_ack(idx, "batch_ack");
      if (idx < 0) begin
        b0.req_in = 4'h0;
        break;
      end
      got[got_n] = idx;
      got_n++;
      b0.req_in[idx] = 1'b0;
      wait_for(1, 4'h0, "batch_release");
    end
  endtask

  vec_t       vt [7];
  int         exp_q [$];
  int         ptr_m;
  int         cnt_m;
  int         idx;
  int         rr_exp [5];
  int         sat_exp [5];
  logic [3:0] r;

  initial begin
    vt[0] = '{4'b0101, 3'd2, {2'd0, 2'd0, 2'd2, 2'd0}};
    vt[1] = '{4'b1111, 3'd4, {2'd2, 2'd1, 2'd0, 2'd3}};
    vt[2] = '{4'b1001, 3'd2, {2'd0, 2'd0, 2'd0, 2'd3}};
    vt[3] = '{4'b0001, 3'd1, {2'd0, 2'd0, 2'd0, 2'd0}};
    vt[4] = '{4'b0110, 3'd2, {2'd0, 2'd0, 2'd2, 2'd1}};
    vt[5] = '{4'b0100, 3'd1, {2'd0, 2'd0, 2'd0, 2'd2}};
    vt[6] = '{4'b1010, 3'd2, {2'd0, 2'd0, 2'd1, 2'd3}};
    rr_exp  = '{0, 1, 2, 3, 0};
    sat_exp = '{1, 2, 3, 3, 3};

    // Reset with all requests high, then release.
    rst        = 1'b1;
    b0.req_in  = 4'hF;
    b0.ack_out = 4'h0;
    b1.req_in  = 4'h0;
    b1.ack_out = 4'h0;
    prev_req   = 4'h0;
    mode       = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_outputs",
          {b0.ack_in, b0.sel, b0.req_out, 3'b0, b0.busy, b0.spike_cnt}, 0);
    end
    rst = 1'b0;
    tick();
    chk("rst_rel_c1", b0.req_out, 4'h0);
    tick();
    chk("rst_rel_c2", b0.req_out, 4'h0);
    tick();
    chk("rst_rel_c3_req_out", b0.req_out, 4'hF);
    chk("rst_rel_c3_sel", b0.sel, 4'b0001);

    // Single transaction with exact latencies.
    do_reset(2);
    mode      = 1;
    b0.req_in = 4'b0010;
    tick();
    tick();
    chk("single_c2_req_out", b0.req_out, 4'h0);
    tick();
    chk("single_c3_sel", b0.sel, 4'b0010);
    chk("single_c3_req_out", b0.req_out, 4'hF);
    chk("single_c3_busy", b0.busy, 1'b1);
    wait_for(1, 4'b0010, "single_ack_in");
    chk("single_sel_stable", b0.sel, 4'b0010);
    b0.req_in = 4'h0;
    tick();
    tick();
    chk("single_drop_c2_ack", b0.ack_in, 4'b0010);
    tick();
    chk("single_drop_c3_ack", b0.ack_in, 4'h0);
    chk("single_cnt", b0.spike_cnt, 16'd1);
    chk("single_idle_sel", b0.sel, 4'h0);

    // Round-robin with immediate re-requests.
    do_reset(2);
    mode      = 1;
    b0.req_in = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_ack(idx, "rr_ack");
      if (idx >= 0) begin
        chk("rr_order", idx, rr_exp[k]);
        b0.req_in[idx] = 1'b0;
        wait_for(1, 4'h0, "rr_release");
        b0.req_in[idx] = 1'b1;
      end
    end

    // Grant-order table from a fresh pointer.
    do_reset(2);
    mode  = 1;
    cnt_m = 0;
    for (int v = 0; v < 7; v++) begin
      run_batch(vt[v].req);
      chk("tbl_count", got_n, vt[v].n);
      for (int k = 0; k < int'(vt[v].n); k++)
        chk("tbl_grant", got[k], vt[v].ord[2*k +: 2]);
      cnt_m += int'(vt[v].n);
      chk("tbl_spike_cnt", b0.spike_cnt, cnt_m);
    end

    // Reset in the middle of a broadcast; pointer returns to 0.
    mode       = 0;
    b0.ack_out = 4'h0;
    b0.req_in  = 4'b1000;
    wait_for(0, 4'hF, "midrst_bcast");
    chk("midrst_sel_before", b0.sel, 4'b1000);
    rst = 1'b1;
    tick();
    chk("midrst_outputs",
        {b0.ack_in, b0.sel, b0.req_out, 3'b0, b0.busy, b0.spike_cnt}, 0);
    rst       = 1'b0;
    b0.req_in = 4'b1001;
    tick();
    tick();
    tick();
    chk("midrst_ptr0_sel", b0.sel, 4'b0001);

    // Partial ack holds the broadcast.
    do_reset(2);
    mode      = 0;
    b0.req_in = 4'b0001;
    wait_for(0, 4'hF, "partial_bcast");
    b0.ack_out = 4'b0111;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("partial_hold", b0.req_out, 4'hF);
    end
    b0.ack_out = 4'hF;
    tick();
    chk("partial_full_c1", b0.req_out, 4'hF);
    tick();
    chk("partial_full_c2", b0.req_out, 4'hF);
    tick();
    chk("partial_full_c3", b0.req_out, 4'h0);
    b0.ack_out = 4'h0;
    wait_for(1, 4'b0001, "partial_ack_in");
    b0.req_in = 4'h0;
    wait_for(1, 4'h0, "partial_release");
    chk("partial_cnt", b0.spike_cnt, 16'd1);

    // Random batches with per-bit random ack timing.
    do_reset(2);
    mode  = 2;
    ptr_m = 0;
    cnt_m = 0;
    for (int b = 0; b < 25; b++) begin
      r = 4'($urandom_range(15, 1));
      exp_q.delete();
      for (int i = 0; i < 4; i++)
        if (r[(ptr_m + i) % 4]) exp_q.push_back((ptr_m + i) % 4);
      ptr_m = (exp_q[exp_q.size() - 1] + 1) % 4;
      cnt_m += exp_q.size();
      run_batch(r);
      chk("rand_count", got_n, exp_q.size());
      for (int k = 0; k < exp_q.size(); k++)
        chk("rand_grant", got[k], exp_q[k]);
      chk("rand_spike_cnt", b0.spike_cnt, cnt_m);
      for (int i = 0; i < int'($urandom_range(3, 0)); i++) tick();
    end

    // Saturating counter on the narrow instance.
    mode = 0;
    do_reset(2);
    for (int k = 0; k < 5; k++) begin
      b1.req_in = 4'b0001;
      wait_for(3, 4'b0001, "sat_ack");
      b1.req_in = 4'h0;
      wait_for(3, 4'h0, "sat_release");
      chk("sat_cnt", b1.spike_cnt, sat_exp[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
